// File: rtl/audio_pkg.sv
// Shared types and constants for the WM8731 configuration block.
package audio_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BYTE,
        ST_ACK,
        ST_STOP,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_t;

    // 7'h1A with the write bit appended
    localparam logic [7:0] WM8731_DEV_WR = 8'h34;
    // 50 MHz / (4 * 125) = 100 kHz SCL
    localparam int         CLK_DIV_100K  = 125;

    // WM8731 register addresses
    localparam logic [6:0] R_LLINE  = 7'd0;
    localparam logic [6:0] R_RLINE  = 7'd1;
    localparam logic [6:0] R_LHP    = 7'd2;
    localparam logic [6:0] R_RHP    = 7'd3;
    localparam logic [6:0] R_APATH  = 7'd4;
    localparam logic [6:0] R_DPATH  = 7'd5;
    localparam logic [6:0] R_PDOWN  = 7'd6;
    localparam logic [6:0] R_IFACE  = 7'd7;
    localparam logic [6:0] R_SRATE  = 7'd8;
    localparam logic [6:0] R_ACTIVE = 7'd9;
    localparam logic [6:0] R_RESET  = 7'd15;

    // Codec control word: 7-bit register address over 9-bit data
    function automatic logic [15:0] reg_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/audio_codec_config_if.sv
// I2C pin bundle between the configuration master and the codec pads.
interface audio_codec_config_if;
    logic i2c_sclk;     // 1 = released, 0 = drive low
    logic i2c_sdat_oe;  // 1 = drive SDA low, 0 = release
    logic sdat_in;      // synchronised SDA pin

    modport master (output i2c_sclk, output i2c_sdat_oe, input sdat_in);
    modport slave  (input i2c_sclk, input i2c_sdat_oe, output sdat_in);
endinterface

// File: rtl/audio_codec_rom.sv
// Fixed WM8731 init table; index beyond the table reads as zero.
module audio_codec_rom
    import audio_pkg::*;
(
    input  logic [3:0]  index,
    output logic [15:0] word
);

    // Table lookup
    always_comb begin
        word = 16'h0000;
        case (index)
            4'd0: word = reg_word(R_RESET,  9'h000);
            4'd1: word = reg_word(R_LLINE,  9'h017);
            4'd2: word = reg_word(R_RLINE,  9'h017);
            4'd3: word = reg_word(R_LHP,    9'h079);
            4'd4: word = reg_word(R_RHP,    9'h079);
            4'd5: word = reg_word(R_APATH,  9'h012);
            4'd6: word = reg_word(R_DPATH,  9'h006);
            4'd7: word = reg_word(R_PDOWN,  9'h000);
            4'd8: word = reg_word(R_IFACE,  9'h001);
            4'd9: word = reg_word(R_ACTIVE, 9'h001);
            default: word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/audio_codec_config.sv
// WM8731 configuration master: on each init rising edge, writes the
// register table over I2C with per-word NACK retry and sticky status.
module audio_codec_config
    import audio_pkg::*;
#(
    parameter int         CLK_DIV     = CLK_DIV_100K,
    parameter logic [7:0] DEV_WR_BYTE = WM8731_DEV_WR,
    parameter int         NUM_REGS    = 10,
    parameter int         MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 init,
    audio_codec_config_if.master i2c,
    output logic                 busy,
    output logic                 done,
    output logic                 ack_err
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t          state, state_n;
    logic [CW-1:0]   tick_cnt;
    logic            qtick;
    logic            init_q;
    logic            start_ok;

    logic [2:0]      ph, ph_n;          // quarter-bit phase; STOP uses 0..7
    logic [2:0]      bit_cnt, bit_n;
    logic [1:0]      byte_cnt, byte_n;  // 0 = address, 1 = high, 2 = low
    logic [3:0]      idx, idx_n;
    logic [RW-1:0]   retry, retry_n;
    logic [RW-1:0]   retry_inc;
    logic [3:0]      idx_inc;
    logic            nack, nack_n;
    logic            sclk_r, sclk_n;
    logic            sda_oe_r, sda_n;
    logic            busy_r, busy_n;
    logic            done_r, done_n;
    logic            err_r, err_n;

    logic [15:0]     word;
    logic [7:0]      tx_byte;
    logic            tx_bit;

    audio_codec_rom u_rom (
        .index (idx),
        .word  (word)
    );

    assign tx_byte   = (byte_cnt == 2'd0) ? DEV_WR_BYTE :
                       (byte_cnt == 2'd1) ? word[15:8] : word[7:0];
    assign tx_bit    = tx_byte[3'd7 - bit_cnt];
    assign retry_inc = retry + RW'(1);
    assign idx_inc   = idx + 4'd1;

    // A new sequence may only begin when nothing is in flight
    assign start_ok = init && !init_q &&
                      (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

    assign qtick = (state != ST_IDLE) && (tick_cnt == CW'(CLK_DIV - 1));

    // Edge detector for the INIT level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) init_q <= 1'b0;
        else          init_q <= init;
    end

    // Quarter-bit tick divider, parked at zero while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                             tick_cnt <= '0;
        else if (state == ST_IDLE || start_ok || qtick) tick_cnt <= '0;
        else                                      tick_cnt <= tick_cnt + CW'(1);
    end

    // State and datapath registers; lines release asynchronously on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ph       <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            idx      <= '0;
            retry    <= '0;
            nack     <= 1'b0;
            sclk_r   <= 1'b1;
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state    <= state_n;
            ph       <= ph_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            idx      <= idx_n;
            retry    <= retry_n;
            nack     <= nack_n;
            sclk_r   <= sclk_n;
            sda_oe_r <= sda_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            err_r    <= err_n;
        end
    end

    // Next-state, bus phase sequencing and status updates
    always_comb begin
        state_n = state;
        ph_n    = ph;
        bit_n   = bit_cnt;
        byte_n  = byte_cnt;
        idx_n   = idx;
        retry_n = retry;
        nack_n  = nack;
        sclk_n  = sclk_r;
        sda_n   = sda_oe_r;
        busy_n  = busy_r;
        done_n  = done_r;
        err_n   = err_r;

        if (start_ok) begin
            state_n = ST_START;
            ph_n    = '0;
            bit_n   = '0;
            byte_n  = '0;
            idx_n   = '0;
            retry_n = '0;
            nack_n  = 1'b0;
            busy_n  = 1'b1;
            done_n  = 1'b0;
            err_n   = 1'b0;
            sclk_n  = 1'b1;
            sda_n   = 1'b0;
        end else begin
            case (state)
                ST_START: if (qtick) begin
                    if (!ph[0]) begin
                        sda_n = 1'b1;           // SDA falls, SCL still high
                        ph_n  = 3'd1;
                    end else begin
                        sclk_n  = 1'b0;
                        ph_n    = '0;
                        bit_n   = '0;
                        byte_n  = '0;
                        nack_n  = 1'b0;
                        state_n = ST_BYTE;
                    end
                end
                ST_BYTE: if (qtick) begin
                    ph_n = ph + 3'd1;
                    case (ph[1:0])
                        2'd0: sda_n  = ~tx_bit;
                        2'd1: sclk_n = 1'b1;
                        2'd3: begin
                            sclk_n = 1'b0;
                            ph_n   = '0;
                            if (bit_cnt == 3'd7) begin
                                bit_n   = '0;
                                state_n = ST_ACK;
                            end else begin
                                bit_n = bit_cnt + 3'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_ACK: if (qtick) begin
                    ph_n = ph + 3'd1;
                    case (ph[1:0])
                        2'd0: sda_n  = 1'b0;
                        2'd1: sclk_n = 1'b1;
                        2'd2: nack_n = i2c.sdat_in;
                        default: begin
                            sclk_n = 1'b0;
                            ph_n   = '0;
                            if (nack || byte_cnt == 2'd2) begin
                                state_n = ST_STOP;
                            end else begin
                                byte_n  = byte_cnt + 2'd1;
                                state_n = ST_BYTE;
                            end
                        end
                    endcase
                end
                // Phases 3..7 hold the bus idle before any following START
                ST_STOP: if (qtick) begin
                    ph_n = ph + 3'd1;
                    case (ph)
                        3'd0: sda_n  = 1'b1;
                        3'd1: sclk_n = 1'b1;
                        3'd2: sda_n  = 1'b0;     // SDA rises with SCL high
                        3'd7: begin
                            ph_n = '0;
                            if (nack) begin
                                retry_n = retry_inc;
                                if (retry_inc == RW'(MAX_RETRY)) begin
                                    state_n = ST_ERR;
                                    busy_n  = 1'b0;
                                    err_n   = 1'b1;
                                end else begin
                                    state_n = ST_START;
                                end
                            end else begin
                                state_n = ST_NEXT;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_NEXT: begin
                    idx_n   = idx_inc;
                    retry_n = '0;
                    if (idx_inc == 4'(NUM_REGS)) begin
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_START;
                    end
                end
                default: begin
                    sclk_n = 1'b1;
                    sda_n  = 1'b0;
                end
            endcase
        end
    end

    assign i2c.i2c_sclk    = sclk_r;
    assign i2c.i2c_sdat_oe = sda_oe_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign ack_err         = err_r;

endmodule

// File: tb/tb_audio_codec_config.sv
// Bench for audio_codec_config: I2C slave model logs each transfer,
// scoreboard of expected transfers, bus timing monitor.
module tb_audio_codec_config;

    localparam int CLK_DIV = 4;
    localparam int BIT_T   = 2 * CLK_DIV;
    localparam int LIMIT   = 20000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic init    = 1'b0;
    logic busy, done, ack_err;
    logic slave_oe = 1'b0;
    logic sda, scl;

    int errors = 0;
    int checks = 0;

    logic [15:0] tbl [10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                              16'h0812, 16'h0A06, 16'h0C00, 16'h0E01, 16'h1201};
    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];

    // slave model state; mode 0 = always ACK, 1 = NACK data byte 04, 2 = NACK address
    int          mode       = 0;
    int          nack_limit = 0;
    int          nack_done  = 0;
    logic        in_xfer    = 1'b0;
    logic        in_ack     = 1'b0;
    int          bitcnt     = 0;
    logic [7:0]  sh         = '0;
    logic [23:0] rx         = '0;
    logic [7:0]  nbytes     = '0;
    logic        scl_p      = 1'b1;
    logic        sda_p      = 1'b1;
    logic        nack_now;

    // timing monitor state
    int   cyc = 0, t_fall = 0, t_rise = 0, t_start = 0, t_stop = 0;
    int   viol = 0, n_low = 0, n_high = 0, n_start = 0;
    logic low_ok = 1'b0, high_ok = 1'b0, start_pend = 1'b0, stop_seen = 1'b0;

    audio_codec_config_if bus ();

    assign sda         = ~(bus.i2c_sdat_oe | slave_oe);
    assign scl         = bus.i2c_sclk;
    assign bus.sdat_in = sda;

    audio_codec_config #(
        .CLK_DIV     (CLK_DIV),
        .DEV_WR_BYTE (8'h34),
        .NUM_REGS    (10),
        .MAX_RETRY   (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (init),
        .i2c     (bus),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err)
    );

    always #5 clk = ~clk;

    assign nack_now = (mode == 2 && nbytes == 8'd0) ||
                      (mode == 1 && nbytes == 8'd1 && sh == 8'h04 && nack_done < nack_limit);

    // I2C slave: decode START/STOP, shift bits on SCL rise, ACK/NACK after each byte
    always @(negedge clk) begin
        scl_p <= scl;
        sda_p <= sda;
        if (!reset_n) begin
            in_xfer  <= 1'b0;
            in_ack   <= 1'b0;
            bitcnt   <= 0;
            slave_oe <= 1'b0;
        end else if (scl_p && scl && sda_p && !sda) begin
            in_xfer  <= 1'b1;
            in_ack   <= 1'b0;
            bitcnt   <= 0;
            nbytes   <= '0;
            rx       <= '0;
            slave_oe <= 1'b0;
        end else if (scl_p && scl && !sda_p && sda) begin
            if (in_xfer) obs_q.push_back({nbytes, rx});
            in_xfer  <= 1'b0;
            in_ack   <= 1'b0;
            bitcnt   <= 0;
            slave_oe <= 1'b0;
        end else if (!scl_p && scl) begin
            if (!in_ack) begin
                sh     <= {sh[6:0], sda};
                bitcnt <= bitcnt + 1;
            end
        end else if (scl_p && !scl) begin
            if (in_ack) begin
                in_ack   <= 1'b0;
                slave_oe <= 1'b0;
            end else if (bitcnt == 8 && in_xfer) begin
                bitcnt <= 0;
                in_ack <= 1'b1;
                if (nbytes < 8'd3) rx[23 - 8*nbytes -: 8] <= sh;
                nbytes   <= nbytes + 8'd1;
                slave_oe <= !nack_now;
                if (nack_now && mode == 1) nack_done <= nack_done + 1;
            end
        end
    end

    // Bus timing monitor: SCL half periods, START hold, idle before START
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            low_ok     <= 1'b0;
            high_ok    <= 1'b0;
            start_pend <= 1'b0;
            stop_seen  <= 1'b0;
        end else if (!scl_p && scl) begin
            if (low_ok) begin
                n_low <= n_low + 1;
                if (cyc - t_fall != BIT_T) viol <= viol + 1;
            end
            low_ok  <= 1'b0;
            high_ok <= 1'b1;
            t_rise  <= cyc;
        end else if (scl_p && !scl) begin
            if (high_ok) begin
                n_high <= n_high + 1;
                if (cyc - t_rise != BIT_T) viol <= viol + 1;
            end
            if (start_pend) begin
                n_start <= n_start + 1;
                if (cyc - t_start < CLK_DIV) viol <= viol + 1;
            end
            high_ok    <= 1'b0;
            start_pend <= 1'b0;
            low_ok     <= 1'b1;
            t_fall     <= cyc;
        end else if (scl_p && scl && sda_p && !sda) begin
            if (stop_seen && cyc - t_stop < 4 * CLK_DIV) viol <= viol + 1;
            start_pend <= 1'b1;
            t_start    <= cyc;
            high_ok    <= 1'b0;
        end else if (scl_p && scl && !sda_p && sda) begin
            stop_seen <= 1'b1;
            t_stop    <= cyc;
            high_ok   <= 1'b0;
        end
    end

    // Produce an init rising edge
    task automatic pulse_init();
        init = 1'b0;
        repeat (3) @(negedge clk);
        init = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Wait for the sequence to leave busy; reports an expired budget
    task automatic wait_idle(output logic timed_out);
        int n;
        n = 0;
        while (busy && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        timed_out = busy;
    endtask

    function automatic logic [31:0] full_xfer(input logic [15:0] w);
        return {8'd3, 8'h34, w};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (scl !== 1'b1)             begin errors++; $display("FAIL reset_sclk got=%b want=1", scl); end
        if (bus.i2c_sdat_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b want=0", bus.i2c_sdat_oe); end
        if (busy !== 1'b0)            begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0)            begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        if (ack_err !== 1'b0)         begin errors++; $display("FAIL reset_ack_err got=%b want=0", ack_err); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full_sequence();
        logic to;
        logic [31:0] e, o;
        mode = 0;
        for (int i = 0; i < 10; i++) exp_q.push_back(full_xfer(tbl[i]));
        pulse_init();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_start got=%b want=1", busy); end
        wait_idle(to);
        checks += 4;
        if (to)               begin errors++; $display("FAIL full_timeout busy still high after %0d cycles", LIMIT); end
        if (done !== 1'b1)    begin errors++; $display("FAIL full_done got=%b want=1", done); end
        if (ack_err !== 1'b0) begin errors++; $display("FAIL full_ack_err got=%b want=0", ack_err); end
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL full_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL full_xfer got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_nack_retry();
        logic to;
        logic [31:0] e, o;
        mode       = 1;
        nack_limit = nack_done + 2;
        for (int i = 0; i < 3; i++) exp_q.push_back(full_xfer(tbl[i]));
        exp_q.push_back({8'd2, 8'h34, 8'h04, 8'h00});
        exp_q.push_back({8'd2, 8'h34, 8'h04, 8'h00});
        for (int i = 3; i < 10; i++) exp_q.push_back(full_xfer(tbl[i]));
        pulse_init();
        wait_idle(to);
        checks += 4;
        if (to)               begin errors++; $display("FAIL retry_timeout busy still high after %0d cycles", LIMIT); end
        if (done !== 1'b1)    begin errors++; $display("FAIL retry_done got=%b want=1", done); end
        if (ack_err !== 1'b0) begin errors++; $display("FAIL retry_ack_err got=%b want=0", ack_err); end
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL retry_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL retry_xfer got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        mode = 0;
    endtask

    task automatic test_nack_abort();
        logic to;
        logic [31:0] e, o;
        mode = 2;
        for (int i = 0; i < 3; i++) exp_q.push_back({8'd1, 8'h34, 16'h0000});
        pulse_init();
        wait_idle(to);
        repeat (2) @(negedge clk);
        checks += 6;
        if (to)                       begin errors++; $display("FAIL abort_timeout busy still high after %0d cycles", LIMIT); end
        if (ack_err !== 1'b1)         begin errors++; $display("FAIL abort_ack_err got=%b want=1", ack_err); end
        if (done !== 1'b0)            begin errors++; $display("FAIL abort_done got=%b want=0", done); end
        if (scl !== 1'b1)             begin errors++; $display("FAIL abort_sclk got=%b want=1", scl); end
        if (bus.i2c_sdat_oe !== 1'b0) begin errors++; $display("FAIL abort_sda_oe got=%b want=0", bus.i2c_sdat_oe); end
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL abort_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL abort_xfer got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        mode = 0;
    endtask

    task automatic test_back_to_back();
        logic to;
        logic [31:0] e, o;
        mode = 0;
        for (int i = 0; i < 10; i++) exp_q.push_back(full_xfer(tbl[i]));
        pulse_init();
        repeat (300) @(negedge clk);
        pulse_init();                       // lands while busy
        wait_idle(to);
        checks += 3;
        if (to)            begin errors++; $display("FAIL b2b_timeout busy still high after %0d cycles", LIMIT); end
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b want=1", done); end
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_xfer got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();

        // init stays high: nothing new may start
        repeat (2000) @(negedge clk);
        checks += 3;
        if (obs_q.size() != 0) begin errors++; $display("FAIL hold_no_xfer got=%0d want=0", obs_q.size()); end
        if (done !== 1'b1)     begin errors++; $display("FAIL hold_done got=%b want=1", done); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL hold_busy got=%b want=0", busy); end

        // fresh edge reruns the table
        for (int i = 0; i < 10; i++) exp_q.push_back(full_xfer(tbl[i]));
        pulse_init();
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL rerun_done_clear got=%b want=0", done); end
        if (busy !== 1'b1) begin errors++; $display("FAIL rerun_busy got=%b want=1", busy); end
        wait_idle(to);
        checks += 3;
        if (to)            begin errors++; $display("FAIL rerun_timeout busy still high after %0d cycles", LIMIT); end
        if (done !== 1'b1) begin errors++; $display("FAIL rerun_done got=%b want=1", done); end
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rerun_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rerun_xfer got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_byte();
        int n;
        pulse_init();
        n = 0;
        while (!(in_xfer && !in_ack && bitcnt >= 3) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= LIMIT) begin errors++; $display("FAIL midbyte_timeout slave idle after %0d cycles", LIMIT); end
        #2 reset_n = 1'b0;
        #1;
        checks += 5;
        if (scl !== 1'b1)             begin errors++; $display("FAIL midbyte_sclk got=%b want=1", scl); end
        if (bus.i2c_sdat_oe !== 1'b0) begin errors++; $display("FAIL midbyte_sda_oe got=%b want=0", bus.i2c_sdat_oe); end
        if (busy !== 1'b0)            begin errors++; $display("FAIL midbyte_busy got=%b want=0", busy); end
        if (done !== 1'b0)            begin errors++; $display("FAIL midbyte_done got=%b want=0", done); end
        if (ack_err !== 1'b0)         begin errors++; $display("FAIL midbyte_ack_err got=%b want=0", ack_err); end
        init = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        checks += 2;
        if (obs_q.size() != 0) begin errors++; $display("FAIL midbyte_no_stop got=%0d want=0", obs_q.size()); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL midbyte_stays_idle got=%b want=0", busy); end
        obs_q.delete();
    endtask

    task automatic test_timing();
        checks += 4;
        if (viol != 0)   begin errors++; $display("FAIL timing_violations got=%0d want=0", viol); end
        if (n_low == 0)  begin errors++; $display("FAIL timing_low_seen got=%0d want>0", n_low); end
        if (n_high == 0) begin errors++; $display("FAIL timing_high_seen got=%0d want>0", n_high); end
        if (n_start == 0) begin errors++; $display("FAIL timing_start_seen got=%0d want>0", n_start); end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_nack_retry();
        test_nack_abort();
        test_back_to_back();
        test_reset_mid_byte();
        test_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_codec_config.md
Name: audio_codec_config

Overview:
Downstream consumer of the audio INIT PIO bit. On each rising edge of `init`, it programs the WM8731 codec over I2C by writing a fixed table of register words. Output is open-drain `i2c_sclk`/`i2c_sdat` to the codec pins, plus status bits. `done` and `ack_err` feed a Nios-readable status PIO so software can poll for completion.

Parameters:
- CLK_DIV, 125: system clocks per quarter SCL period (50 MHz -> 100 kHz SCL).
- DEV_WR_BYTE, 8'h34: I2C address byte, 7'h1A plus W bit.
- NUM_REGS, 10: number of table entries written per init.
- MAX_RETRY, 3: retries per word after a NACK before giving up.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- init  in  1  level from the INIT PIO; the rising edge starts a sequence.
- sdat_in  in  1  sampled SDA pin (externally synchronised, 2 FF).
- i2c_sclk  out  1  SCL; 1 = released (high-Z externally), 0 = drive low.
- i2c_sdat_oe  out  1  1 = drive SDA low; 0 = release.
- busy  out  1  high while a sequence is in progress.
- done  out  1  sticky; high after all NUM_REGS words were ACKed.
- ack_err  out  1  sticky; high after MAX_RETRY NACKs on one word.

Behaviour:
- Reset values: i2c_sclk=1, i2c_sdat_oe=0, busy=0, done=0, ack_err=0. Internal state: FSM=IDLE, index=0, retry=0, tick counter=0.
- Async reset mid-transfer releases both lines immediately. No STOP is generated.
- Tick generator:
  - Counter 0..CLK_DIV-1 produces a 1-cycle `qtick`.
  - The counter runs only when FSM != IDLE.
  - Each I2C bit uses 4 qticks. Phase 0: set SDA with SCL low. Phase 1: raise SCL. Phase 2: sample sdat_in. Phase 3: lower SCL.
- Init edge detection:
  - `init_q` is registered; start = init & ~init_q, accepted only in IDLE/DONE/ERR.
  - On accepted start: done=0, ack_err=0, index=0, retry=0, busy=1, enter START.
  - An edge while busy is ignored. Holding init high does not retrigger.
- FSM states:
  - IDLE: lines released.
  - START: SDA falls while SCL high (2 qticks).
  - BYTE: shift out 8 bits MSB first.
  - ACK: release SDA for one bit time, sample at phase 2; 0 = ACK.
  - STOP: SDA rises while SCL high.
  - NEXT, DONE, ERR: see transfers and completion below.
- Transfer framing:
  - Each word is START, DEV_WR_BYTE, ACK, word[15:8], ACK, word[7:0], ACK, STOP.
  - Byte counter runs 0..2.
- NACK handling:
  - On any NACK: go to STOP, then retry++.
  - If retry == MAX_RETRY, go to ERR (ack_err=1, busy=0). Otherwise re-send the same word from START.
- Completion:
  - After STOP of an ACKed word, NEXT sets index++ and retry=0.
  - If index == NUM_REGS, go to DONE (done=1, busy=0); otherwise go to START.
  - The 4-bit index wraps only via a new start.
- Bus idle rule: at least 4 qticks of idle time between STOP and the next START.

Decomposition:
- Shared package `audio_pkg`:
  - FSM state enum.
  - Constants WM8731_DEV_WR, CLK_DIV_100K.
  - Register-address localparams (R_LLINE=0 ... R_ACTIVE=9, R_RESET=15).
- Sub-module `audio_codec_rom`: combinational index[3:0] -> word[15:0].
- Table contents:
  - 0: 1E00 (reset)
  - 1: 0017, 2: 0217 (line-in volume)
  - 3: 0479, 4: 0679 (headphone volume)
  - 5: 0812 (DAC select)
  - 6: 0A06
  - 7: 0C00 (power up)
  - 8: 0E01 (left-justified, 16 bit)
  - 9: 1201 (active)
  - Out-of-range index returns 0000.

Test Plan:
- Reset mid-byte (assert reset_n=0 during BYTE) -> i2c_sclk=1 and i2c_sdat_oe=0 same cycle; busy/done/ack_err=0.
- init 0->1 with the I2C slave model always ACKing:
  - Slave log shows 10 transfers: 34 1E 00, 34 00 17, 34 02 17, ..., 34 12 01.
  - done=1 and busy=0 after ~10*29 bit times; no ack_err.
- Slave NACKs the first byte of word 3 exactly twice:
  - Word 3 is sent 3 times with a STOP between attempts.
  - The sequence completes with done=1 and ack_err=0.
- Slave always NACKs the address byte:
  - 3 attempts of word 0, then ack_err=1, done=0, busy=0; lines released.
- Second init rising edge during busy -> ignored; exactly 10 transfers. init held high after DONE -> no new transfer. Toggle 1->0->1 -> done clears and the sequence reruns.
- Timing check with CLK_DIV=125:
  - SCL high and low periods = 250 clks each.
  - SDA changes only while SCL low, except START/STOP.
  - START hold >= 125 clks.
